// File: rtl/aes_pkg.sv
// Shared AES constants and types for the round-key datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int KEY_W   = 128;

  // Occupancy of the main/skid output buffer pair.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ark_xor.sv
// AddRoundKey combinational core: bitwise XOR of state and round key.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller owns all flow control.
//
// Ports:
//   in_state  - AES state, byte 0 at the MSB end
//   round_key - round key, same byte order as in_state
//   out_state - in_state XOR round_key
module ark_xor
  import aes_pkg::*;
(
  input  logic [STATE_W-1:0] in_state,
  input  logic [KEY_W-1:0]   round_key,
  output logic [STATE_W-1:0] out_state
);

  assign out_state = in_state ^ round_key;

endmodule

// File: rtl/add_round_key_encr.sv
// AddRoundKey stage with valid/ready handshake and a 2-entry skid buffer.
// Latency: 1 cycle from input accept to out_valid; 1 transfer/cycle sustained.
// Backpressure: in_ready is registered and drops only once the skid entry is full.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_state, round_key  - operands, qualified by in_valid/in_ready
//   in_valid, in_ready   - upstream handshake
//   out_state            - result at the head of the buffer
//   out_valid, out_ready - downstream handshake
module add_round_key_encr
  import aes_pkg::*;
#(
  parameter int DATA_W = 128  // only 128 is supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_state,
  input  logic [DATA_W-1:0] round_key,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_state,
  output logic              out_valid,
  input  logic              out_ready
);

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] xor_res;
  logic              acc;
  logic              cons;

  ark_xor u_ark_xor (
    .in_state  (in_state),
    .round_key (round_key),
    .out_state (xor_res)
  );

  assign acc  = in_valid & in_ready_q;
  assign cons = out_valid_q & out_ready;

  // Main always holds the oldest result; skid only fills when main is
  // stalled and a new input arrives in the same cycle.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (acc) begin
          main_d = xor_res;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && cons) begin
          main_d = xor_res;
        end else if (cons) begin
          occ_d = OCC_EMPTY;
        end else if (acc) begin
          skid_d = xor_res;
          occ_d  = OCC_TWO;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only a consume can happen.
        if (cons) begin
          main_d = skid_q;
          occ_d  = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
  end

  // Handshake flags are registered from next-state occupancy so neither
  // depends combinationally on out_ready or in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= OCC_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      occ_q       <= occ_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (occ_d != OCC_EMPTY);
      in_ready_q  <= (occ_d != OCC_TWO);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = main_q;

endmodule

// File: tb/tb_add_round_key_encr.sv
// Self-checking bench for add_round_key_encr: directed scenarios plus a
// randomized valid/ready soak against a FIFO reference model.
module tb_add_round_key_encr;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_state;
  logic [127:0] round_key;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_state;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: results in flight, oldest first; capacity 2.
  logic [127:0] exp_q[$];
  bit           post_rst = 1'b0;

  add_round_key_encr #(.DATA_W(128)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_state  (in_state),
    .round_key (round_key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      post_rst = 1'b1;
    end else begin
      chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
      if (post_rst) begin
        chk("rst_out_state", out_state, 128'h0);
        post_rst = 1'b0;
      end
      if (out_valid && exp_q.size() != 0)
        chk("out_state", out_state, exp_q[0]);
      if (out_valid && out_ready && exp_q.size() != 0)
        void'(exp_q.pop_front());
      if (in_valid && in_ready)
        exp_q.push_back(in_state ^ round_key);
    end
  end

  task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k,
                       input logic ordy);
    in_valid  = v;
    in_state  = s;
    round_key = k;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] s0, k0, x;
    int           acc_cnt;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    round_key = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'h0);
    chk("reset_in_ready", 128'(in_ready), 128'h1);
    chk("reset_out_state", out_state, 128'h0);
    rst = 1'b0;

    // Known-answer vector.
    drive(1'b1, 128'hc9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9,
          128'hac19285777fad15c66dc2900f321415a, 1'b1);
    chk("kat_valid", 128'(out_valid), 128'h1);
    chk("kat_state", out_state, 128'h65d0e19ebe331895af15e0c93ae88893);

    // Zero state passes the key through; equal operands cancel.
    x = rnd128();
    drive(1'b1, 128'h0, x, 1'b1);
    chk("zero_state", out_state, x);
    drive(1'b1, x, x, 1'b1);
    chk("self_cancel", out_state, 128'h0);
    drive(1'b0, '0, '0, 1'b1);

    // Back-to-back with out_ready high: full throughput, in_ready stays 1.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, rnd128(), rnd128(), 1'b1);
      chk("b2b_in_ready", 128'(in_ready), 128'h1);
      chk("b2b_valid", 128'(out_valid), 128'h1);
    end
    drive(1'b0, '0, '0, 1'b1);

    // Stall: three offers, only two fit; head stays frozen.
    s0 = rnd128();
    k0 = rnd128();
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_state  = (i == 0) ? s0 : rnd128();
      round_key = (i == 0) ? k0 : rnd128();
      out_ready = 1'b0;
      @(negedge clk);
      if (in_ready) acc_cnt++;
      @(posedge clk);
      #1;
    end
    chk("stall_accepts", 128'(acc_cnt), 128'd2);
    chk("stall_in_ready", 128'(in_ready), 128'h0);
    chk("stall_head", out_state, s0 ^ k0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b1);
    chk("stall_drained", 128'(out_valid), 128'h0);

    // Reset with both entries full.
    drive(1'b1, rnd128(), rnd128(), 1'b0);
    drive(1'b1, rnd128(), rnd128(), 1'b0);
    chk("full_before_rst", 128'(in_ready), 128'h0);
    rst = 1'b1;
    drive(1'b1, rnd128(), rnd128(), 1'b1);
    rst = 1'b0;
    chk("rst_full_valid", 128'(out_valid), 128'h0);
    chk("rst_full_state", out_state, 128'h0);
    chk("rst_full_ready", 128'(in_ready), 128'h1);

    // Random soak with a mid-stream reset.
    for (int i = 0; i < 10000; i++) begin
      rst = (i == 5000);
      drive(1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1);
    chk("final_empty", 128'(out_valid), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
